mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Write-side initiator for the single-port 64x8 memory. Accepts a byte stream over a
//  valid/ready handshake and writes it to sequential addresses starting at 0. It then
//  reads every written location back and compares a mod-2^W sum of the read data with
//  the sum of the written data. Used to fill instruction/data memory before the core starts.
// PARAMETERS
//  A  6  memory address width; depth = 2^A
//  W  8  memory data width
// PORTS
//  Clk       in   1    clock; all state updates on the rising edge
//  ResetN    in   1    asynchronous reset, active low
//  Start     in   1    begin a load; sampled only in IDLE
//  Length    in   A+1  bytes to load, 0..2^A; sampled on the accepted Start; values >2^A clamp to 2^A
//  InValid   in   1    stream byte valid
//  InData    in   W    stream byte
//  InReady   out  1    loader can accept a byte
//  MemWe     out  1    memory write enable, registered
//  MemAddr   out  A    memory address, registered
//  MemWData  out  W    memory write data, registered
//  MemRData  in   W    memory read data; combinational from MemAddr in the same cycle
//  Busy      out  1    high in any state other than IDLE
//  Done      out  1    one-cycle pulse at end of verify
//  Error     out  1    readback sum mismatch; sticky until the next accepted Start or reset
//  Checksum  out  W    mod-2^W sum of the accepted bytes; held after Done
// BEHAVIOUR
//  Reset (ResetN=0, any state): go to IDLE. InReady, MemWe, Busy, Done and Error are 0.
//   MemAddr, MemWData and Checksum are 0. All counters are 0.
//  FSM states: IDLE, LOAD, VERIFY, FINISH.
//  IDLE:
//   - Start=1: latch Length (clamped), clear Checksum, Error and counters, go to LOAD.
//   - Start while Busy is ignored.
//  LOAD:
//   - InReady = (acc_cnt != len); this is combinational from the state registers.
//   - Beat = InValid & InReady. On a beat, the next cycle has MemWe=1, MemAddr=acc_cnt and
//     MemWData=InData. In the same edge, acc_cnt++ and Checksum += InData (mod 2^W).
//   - Full throughput: one write per cycle with back-to-back beats.
//   - MemWe=0 in any cycle with no beat in the prior cycle. InData is ignored when InReady=0.
//   - Exit to VERIFY on the edge where acc_cnt==len and no write is pending.
//     The last write has been issued by then.
//  VERIFY:
//   - MemWe=0. MemAddr = v_cnt for v_cnt = 0..len-1, one address per cycle.
//   - Each cycle: rd_sum += MemRData.
//   - Go to FINISH after the read at address len-1. With len=0, no reads occur.
//  FINISH: Error = (rd_sum != Checksum); Done=1 for one cycle; go to IDLE.
//  Address wrap: len=2^A uses addresses 0..2^A-1. Counters are A+1 bits and MemAddr is
//   their low A bits, so MemAddr never wraps to 0 within a load.
//  Latency: Start to first InReady = 1 cycle. Last beat to Done = len+2 cycles.
//  Reset mid-operation aborts immediately. Memory contents written so far are not restored.
// TESTING
//  1 A=6,W=8. Length=4; bytes 11,22,33,44 back-to-back
//    -> writes addr 0..3 on 4 consecutive cycles; Checksum=AA, Error=0, one Done pulse.
//  2 Length=3; InValid toggles 1,0,0,1,0,1
//    -> exactly 3 writes at addr 0,1,2; MemWe=0 in gap cycles; InReady=0 after the 3rd beat.
//  3 Length=64; bytes 00..3F
//    -> MemAddr 00..3F, never >3F; Checksum=E0; 64 verify reads; Error=0.
//    Length=100 -> clamped to 64.
//  4 Length=4; bench memory model corrupts addr 2 (XOR 01) -> Error=1 with Done; Error stays
//    1 until the next Start; a clean reload then gives Error=0.
//  5 Length=0 -> no MemWe, InReady never 1, Done pulse 3 cycles after Start, Checksum=00.
//  6 ResetN=0 after 2 of 5 beats -> same cycle: IDLE, all outputs 0. Start pulsed during
//    VERIFY -> ignored; len is unchanged.

Source files
------------

// File: rtl/mem_loader.sv
// Streams bytes into sequential memory addresses starting at 0, then reads them back
// and compares a modular sum of the readback against the sum of the accepted bytes.
module mem_loader #(
  parameter int A = 6,
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         Start,
  input  logic [A:0]   Length,
  input  logic         InValid,
  input  logic [W-1:0] InData,
  output logic         InReady,
  output logic         MemWe,
  output logic [A-1:0] MemAddr,
  output logic [W-1:0] MemWData,
  input  logic [W-1:0] MemRData,
  output logic         Busy,
  output logic         Done,
  output logic         Error,
  output logic [W-1:0] Checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};

  logic [1:0]   state_reg;
  logic [A:0]   len_reg;
  logic [A:0]   acc_cnt_reg;
  logic [A:0]   v_cnt_reg;
  logic [W-1:0] rd_sum_reg;
  logic [W-1:0] checksum_reg;
  logic         mem_we_reg;
  logic [A-1:0] mem_addr_reg;
  logic [W-1:0] mem_wdata_reg;
  logic         error_reg;

  logic         beat;
  logic [A:0]   v_cnt_next;
  logic [W-1:0] rd_sum_next;

  assign InReady     = (state_reg == S_LOAD) && (acc_cnt_reg != len_reg);
  assign beat        = InValid && InReady;
  assign v_cnt_next  = v_cnt_reg + 1'b1;
  assign rd_sum_next = rd_sum_reg + MemRData;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      acc_cnt_reg   <= '0;
      v_cnt_reg     <= '0;
      rd_sum_reg    <= '0;
      checksum_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            len_reg      <= (Length > DEPTH) ? DEPTH : Length;
            checksum_reg <= '0;
            error_reg    <= 1'b0;
            acc_cnt_reg  <= '0;
            v_cnt_reg    <= '0;
            rd_sum_reg   <= '0;
            state_reg    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (beat) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= acc_cnt_reg[A-1:0];
            mem_wdata_reg <= InData;
            acc_cnt_reg   <= acc_cnt_reg + 1'b1;
            checksum_reg  <= checksum_reg + InData;
          end else if (acc_cnt_reg == len_reg) begin
            // The final write is on the bus this cycle and lands on this same edge.
            state_reg    <= S_VERIFY;
            mem_addr_reg <= '0;
            v_cnt_reg    <= '0;
          end
        end
        S_VERIFY: begin
          if (v_cnt_reg == len_reg) begin
            // Only reachable with an empty load: nothing to read back.
            error_reg    <= (rd_sum_reg != checksum_reg);
            state_reg    <= S_FINISH;
          end else begin
            rd_sum_reg   <= rd_sum_next;
            v_cnt_reg    <= v_cnt_next;
            mem_addr_reg <= v_cnt_next[A-1:0];
            if (v_cnt_next == len_reg) begin
              error_reg    <= (rd_sum_next != checksum_reg);
              mem_addr_reg <= '0;
              state_reg    <= S_FINISH;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign MemWe    = mem_we_reg;
  assign MemAddr  = mem_addr_reg;
  assign MemWData = mem_wdata_reg;
  assign Busy     = (state_reg != S_IDLE);
  assign Done     = (state_reg == S_FINISH);
  assign Error    = error_reg;
  assign Checksum = checksum_reg;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued as beats are driven and
// retired as MemWe appears; a behavioural 64x8 memory answers the verify reads.
module tb_mem_loader;
  localparam int A = 6;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         ResetN = 1'b0;
  logic         Start = 1'b0;
  logic [A:0]   Length = '0;
  logic         InValid = 1'b0;
  logic [W-1:0] InData = '0;
  logic         InReady;
  logic         MemWe;
  logic [A-1:0] MemAddr;
  logic [W-1:0] MemWData;
  logic [W-1:0] MemRData;
  logic         Busy;
  logic         Done;
  logic         Error;
  logic [W-1:0] Checksum;

  mem_loader #(.A(A), .W(W)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Length(Length),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .Busy(Busy), .Done(Done), .Error(Error), .Checksum(Checksum)
  );

  always #5 Clk = ~Clk;

  logic [W-1:0] mem [0:63];
  logic         corrupt = 1'b0;
  assign MemRData = mem[MemAddr] ^ ((corrupt && MemAddr == 6'd2) ? 8'h01 : 8'h00);
  always @(posedge Clk) if (MemWe) mem[MemAddr] <= MemWData;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [W-1:0] stim [0:63];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (ResetN && MemWe) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'(MemAddr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", 32'(MemAddr), 32'(mon_e.addr));
        check_val("wr_data", 32'(MemWData), 32'(mon_e.data));
        $display("write addr=%02h data=%02h", MemAddr, MemWData);
      end
    end
  end

  function automatic logic [31:0] out_vec();
    return 32'({InReady, MemWe, Busy, Done, Error, MemAddr, MemWData, Checksum});
  endfunction

  task automatic start_load(input int len, input string tag);
    @(negedge Clk);
    Start  = 1'b1;
    Length = 7'(len);
    @(negedge Clk);
    Start = 1'b0;
    check_val({tag, "_start_ready"}, 32'(InReady), (len != 0) ? 32'd1 : 32'd0);
    check_val({tag, "_start_err_clr"}, 32'(Error), 32'd0);
  endtask

  task automatic send_stream(input int n, input logic [15:0] pat, input int pat_len,
                             output logic [W-1:0] sum);
    int idx = 0;
    int t = 0;
    int guard = 0;
    wr_t w;
    sum = '0;
    while (idx < n && guard < 500) begin
      @(negedge Clk);
      guard++;
      InValid = pat[t % pat_len];
      InData  = stim[idx];
      t++;
      if (InValid && InReady) begin
        w.addr = idx[A-1:0];
        w.data = stim[idx];
        exp_q.push_back(w);
        sum = sum + stim[idx];
        idx++;
      end
    end
    check_val("stream_beats", 32'(idx), 32'(n));
  endtask

  task automatic wait_done(input int exp_cycles, input logic [W-1:0] exp_sum,
                           input logic exp_err, input string tag);
    int c = 0;
    logic seen = 1'b0;
    logic ready_seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge Clk);
      InValid = 1'b0;
      Start   = 1'b0;
      c++;
      if (InReady) ready_seen = 1'b1;
      if (Done) seen = 1'b1;
    end
    check_val({tag, "_done_latency"}, 32'(c), 32'(exp_cycles));
    check_val({tag, "_ready_after_load"}, 32'(ready_seen), 32'd0);
    check_val({tag, "_checksum"}, 32'(Checksum), 32'(exp_sum));
    check_val({tag, "_error"}, 32'(Error), 32'(exp_err));
    check_val({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    $display("%s: done after %0d cycles checksum=%02h error=%0b", tag, c, Checksum, Error);
    @(negedge Clk);
    check_val({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check_val({tag, "_idle"}, 32'(Busy), 32'd0);
    check_val({tag, "_checksum_held"}, 32'(Checksum), 32'(exp_sum));
  endtask

  initial begin
    logic [W-1:0] sum;
    int wr_base;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (2) @(negedge Clk);
    check_val("reset_outputs", out_vec(), 32'd0);
    ResetN = 1'b1;

    // Back-to-back load of four bytes.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    wr_base = n_wr;
    start_load(4, "t1");
    send_stream(4, 16'hFFFF, 1, sum);
    check_val("t1_sum_model", 32'(sum), 32'hAA);
    wait_done(6, 8'hAA, 1'b0, "t1");
    check_val("t1_writes", 32'(n_wr - wr_base), 32'd4);

    // Gapped valid pattern 1,0,0,1,0,1.
    stim[0] = 8'hA5; stim[1] = 8'h5A; stim[2] = 8'hC3;
    wr_base = n_wr;
    start_load(3, "t2");
    send_stream(3, 16'b101001, 6, sum);
    wait_done(5, 8'hC2, 1'b0, "t2");
    check_val("t2_writes", 32'(n_wr - wr_base), 32'd3);

    // Full depth, then an oversized length that must clamp to the same load.
    for (int i = 0; i < 64; i++) stim[i] = 8'(i);
    start_load(64, "t3");
    send_stream(64, 16'hFFFF, 1, sum);
    wait_done(66, 8'hE0, 1'b0, "t3");
    for (int i = 0; i < 64; i++) stim[i] = 8'(63 - i);
    wr_base = n_wr;
    start_load(100, "t3c");
    send_stream(64, 16'hFFFF, 1, sum);
    wait_done(66, 8'hE0, 1'b0, "t3c");
    check_val("t3c_writes", 32'(n_wr - wr_base), 32'd64);

    // Corrupted readback at address 2, sticky error, then a clean reload.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
    corrupt = 1'b1;
    start_load(4, "t4");
    send_stream(4, 16'hFFFF, 1, sum);
    wait_done(6, 8'hAA, 1'b1, "t4");
    repeat (3) @(negedge Clk);
    check_val("t4_error_sticky", 32'(Error), 32'd1);
    corrupt = 1'b0;
    start_load(4, "t4r");
    send_stream(4, 16'hFFFF, 1, sum);
    wait_done(6, 8'hAA, 1'b0, "t4r");

    // Empty load.
    wr_base = n_wr;
    start_load(0, "t5");
    wait_done(2, 8'h00, 1'b0, "t5");
    check_val("t5_writes", 32'(n_wr - wr_base), 32'd0);

    // Start during VERIFY must not disturb the running load.
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
    start_load(4, "t6v");
    send_stream(4, 16'hFFFF, 1, sum);
    @(negedge Clk);
    InValid = 1'b0;
    @(negedge Clk);
    Start  = 1'b1;
    Length = 7'd1;
    wait_done(4, 8'h0A, 1'b0, "t6v");

    // Reset after two of five beats aborts at once.
    for (int i = 0; i < 5; i++) stim[i] = 8'h30 + 8'(i);
    start_load(5, "t6r");
    send_stream(2, 16'hFFFF, 1, sum);
    @(negedge Clk);
    InValid = 1'b0;
    #1 ResetN = 1'b0;
    #1 check_val("t6r_reset_outputs", out_vec(), 32'd0);
    exp_q.delete();
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    check_val("t6r_after_reset", out_vec(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
